// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: run request, ratio handshake and divided-clock status
// bundle between a controlling master and the clk_div_ctrl slave.
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [DIV_W-1:0] cur_div;
    logic             clk_div;
    logic             tick;
    logic             busy;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, cur_div, clk_div, tick, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, cur_div, clk_div, tick, busy
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable integer clock divider, ratio applied only at period
// boundaries. Define ODD_DUTY50_EN for exact 50% duty on odd ratios (negedge flop).
module clk_div_ctrl #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] DEF_Q = DIV_W'(DEF_DIV);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             wrap;
    logic             xfer;
    logic             legal;
    logic [DIV_W:0]   half;

    assign wrap  = (state_q == RUN) && (cnt_q == cur_div_q - DIV_W'(1));
    assign xfer  = bus.cfg_valid && !pend_vld_q;
    assign legal = bus.cfg_div >= DIV_W'(2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) state_d = RUN;
            end
            RUN: begin
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = bus.en ? RUN : STOP;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                cnt_d   = '0;
                state_d = bus.en ? RUN : IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A ratio arriving on the wrap cycle bypasses the pending slot entirely.
    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        err_d      = xfer && !legal;
        if (pend_vld_q && (state_q != RUN || wrap)) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end
        if (xfer && legal) begin
            if (wrap) begin
                cur_div_d = bus.cfg_div;
            end else begin
                pend_div_d = bus.cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

`ifdef ODD_DUTY50_EN
    assign half = {1'b0, cur_div_d} >> 1;
`else
    assign half = ({1'b0, cur_div_d} + (DIV_W+1)'(1)) >> 1;
`endif

    always_comb begin
        p_d    = (state_d == RUN) && ({1'b0, cnt_d} < half);
        tick_d = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_div_q  <= DEF_Q;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            p_q        <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            p_q        <= p_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

`ifdef ODD_DUTY50_EN
    logic n_q;

    // Half-cycle stretch of the high phase; only used for odd ratios.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) n_q <= 1'b0;
        else     n_q <= p_q;
    end

    assign bus.clk_div = p_q | (n_q & cur_div_q[0]);
`else
    assign bus.clk_div = p_q;
`endif

    assign bus.cfg_ready = !pend_vld_q;
    assign bus.cfg_err   = err_q;
    assign bus.cur_div   = cur_div_q;
    assign bus.tick      = tick_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
